// File: rtl/sls_mux_pkg.sv
// sls_mux_pkg: shared mode/state encodings and clog2 helper for the round-robin mux.
package sls_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sls_rr_arbiter_v.sv
// sls_rr_arbiter_v: combinational grant selection, fixed select or round-robin after last_grant.
module sls_rr_arbiter_v
  import sls_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last_grant,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic [SW-1:0] grant,
  output logic          grant_vld
);
  logic [SW-1:0] rr_grant;
  logic          rr_vld;
  logic          fixed_vld;
  int            idx;
  always_comb begin
    rr_grant = '0;
    rr_vld   = 1'b0;
    idx      = 0;
    // scan farthest to nearest so the nearest requester after last_grant wins
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (req[idx]) begin
        rr_grant = SW'(idx);
        rr_vld   = 1'b1;
      end
    end
  end
  assign fixed_vld = (int'(sel) < N) && req[sel];
  assign grant     = (mode == MODE_RR) ? rr_grant : sel;
  assign grant_vld = (mode == MODE_RR) ? rr_vld : fixed_vld;
endmodule

// File: rtl/sls_nbit_rrmux_v.sv
// sls_nbit_rrmux_v: registered N-channel valid/ready mux, fixed or round-robin select.
// Define SLS_RRMUX_CNT_EN to add the 16-bit xfer_cnt transfer counter output.
module sls_nbit_rrmux_v
  import sls_mux_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_chan
`ifdef SLS_RRMUX_CNT_EN
  , output logic [15:0]  xfer_cnt
`endif
);
  state_t        st;
  logic [SW-1:0] last_grant;
  logic [SW-1:0] grant;
  logic          grant_vld;
  logic          elig;
  logic          free;
  logic          xfer;
  logic [W-1:0]  word;
  sls_rr_arbiter_v #(.N(N), .SW(SW)) u_arb (
    .req       (in_valid),
    .last_grant(last_grant),
    .mode      (mode),
    .sel       (sel),
    .grant     (grant),
    .grant_vld (grant_vld)
  );
  assign out_valid = (st == ST_FULL);
  assign free      = rst_n & (!out_valid | out_ready);
  // fixed mode offers ready on sel even when idle; RR only offers it to a requester
  assign elig      = (mode == MODE_RR) ? grant_vld : (int'(sel) < N);
  assign xfer      = free & grant_vld;
  assign word      = in_data[int'(grant)*W +: W];
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = free & elig & (grant == SW'(i));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_EMPTY;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= SW'(N-1);
    end else if (xfer) begin
      st       <= ST_FULL;
      out_data <= word;
      out_chan <= grant;
      if (mode == MODE_RR) last_grant <= grant;
    end else if (out_ready) begin
      st <= ST_EMPTY;
    end
  end
`ifdef SLS_RRMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt <= '0;
    else if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif
endmodule
